tinyalu_arbiter: RTL and testbench

TINYALU_ARBITER -- requirements
Module: tinyalu_arbiter

---
 rtl/tinyalu_pkg.sv | 27 ++
 rtl/tinyalu_arbiter_rr.sv | 31 +++
 rtl/tinyalu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: TinyALU opcode encoding, arbiter state type and
// a small opcode classification helper shared by the arbiter.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    NOP,
    RST,
    RESP
  } arb_state_t;

  // True for opcodes that run on the ALU and wait for done.
  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {add_op, and_op, xor_op, mul_op};
  endfunction

endpackage

// File: rtl/tinyalu_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first valid requester after
// last_i. Ports: valid_i, last_i in; one-hot grant_o and idx_o out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Walk from farthest to nearest so the nearest valid
  // requester after last_i is the one left standing.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (valid_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: shares one TinyALU among NUM_REQ requesters,
// one command at a time, with round-robin grant.
// Ports: req_* per-requester commands (packed, slice i = requester i),
// rsp_* one-hot response, alu_* TinyALU drive/return, busy.
// Optional: define TINYALU_ARB_TIMEOUT_EN to abort EXEC after
// TIMEOUT_CYCLES without alu_done (error response, ALU reset pulse).
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*3-1:0] req_op,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic                 alu_start,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic                 alu_reset_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  arb_state_t         state_q;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      owner_q;
  logic [2:0]         op_q;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [15:0]        res_q;
  logic               err_q;
  logic               start_q;
  logic               rstn_q;
  logic [NUM_REQ-1:0] rsp_q;
  logic [CW-1:0]      cnt_q;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [2:0]         g_op;
  logic [7:0]         g_a;
  logic [7:0]         g_b;
  logic [NUM_REQ-1:0] owner_oh;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign g_op     = req_op[3*gidx +: 3];
  assign g_a      = req_a[8*gidx +: 8];
  assign g_b      = req_b[8*gidx +: 8];
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // Gated by reset so nothing is accepted while reset is held.
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_q;
  assign rsp_result  = res_q;
  assign rsp_error   = err_q;
  assign alu_start   = start_q;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_reset_n = rstn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      rstn_q  <= 1'b0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      rstn_q <= 1'b1;
      rsp_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (|grant) begin
            last_q  <= gidx;
            owner_q <= gidx;
            op_q    <= g_op;
            a_q     <= g_a;
            b_q     <= g_b;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            unique case (1'b1)
              (g_op == no_op): begin
                start_q <= 1'b1;
                state_q <= NOP;
              end
              (g_op == rst_op): begin
                rstn_q  <= 1'b0;
                state_q <= RST;
              end
              is_alu_op(g_op): begin
                start_q <= 1'b1;
                state_q <= EXEC;
              end
              default: begin
                err_q   <= 1'b1;
                rsp_q   <= grant;
                state_q <= RESP;
              end
            endcase
          end
        end
        EXEC: begin
          if (alu_done) begin
            res_q   <= alu_result;
            start_q <= 1'b0;
            rsp_q   <= owner_oh;
            state_q <= RESP;
          end else if (TO_EN &&
                       cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            start_q <= 1'b0;
            rstn_q  <= 1'b0;
            err_q   <= 1'b1;
            res_q   <= '0;
            rsp_q   <= owner_oh;
            state_q <= RESP;
          end else if (TO_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        NOP: begin
          start_q <= 1'b0;
          rsp_q   <= owner_oh;
          state_q <= RESP;
        end
        RST: begin
          rsp_q   <= owner_oh;
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed and randomized checks of the
// TinyALU arbiter against a behavioural command model.
module tb_tinyalu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic        rsp_error;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int last_m   = 3;

  typedef struct {
    int          gidx;
    int          lat;
    int          starts;
    int          first;
    int          rlow;
    int          rdy_bad;
    int          busy_cnt;
    logic [3:0]  rspv;
    logic [15:0] res;
    logic        err;
    bit          post_ok;
  } obs_t;

  always #5 clk = ~clk;

  tinyalu_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .alu_start   (alu_start),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reset_n (alu_reset_n),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int last);
    int c = last;
    repeat (4) begin
      c = (c + 1) % 4;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    alu_done  = 1'b0;
    step();
    reset = 1'b0;
    step();
    last_m = 3;
  endtask

  // Plays requesters and the TinyALU for one command; returns what it saw.
  task automatic run_cmd(input logic [3:0] mask, input logic [11:0] ops,
                         input logic [31:0] as, input logic [31:0] bs,
                         input int k, output obs_t o);
    logic [2:0] op;
    bit ex;
    bit got_rsp;
    o.gidx = -1; o.lat = -1; o.starts = 0; o.first = -1; o.rlow = 0;
    o.rdy_bad = 0; o.busy_cnt = 0; o.rspv = '0; o.res = '0;
    o.err = 1'b0; o.post_ok = 1'b0;
    req_op = ops; req_a = as; req_b = bs; req_valid = mask;
    for (int w = 0; w < 30 && o.gidx < 0; w++) begin
      alu_done   = 1'($urandom_range(0, 1));
      alu_result = 16'($urandom);
      #1;
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) o.gidx = i;
        if (!$onehot(req_ready)) o.rdy_bad++;
      end else begin
        step();
      end
    end
    if (o.gidx < 0) begin
      req_valid = '0;
      alu_done  = 1'b0;
      return;
    end
    op = ops[3*o.gidx +: 3];
    ex = op inside {3'd1, 3'd2, 3'd3, 3'd4};
    step();
    req_valid = mask & ~(4'b0001 << o.gidx);
    got_rsp = 1'b0;
    for (int t = 1; t <= 60 && !got_rsp; t++) begin
      alu_done   = ex ? (t == k) : 1'($urandom_range(0, 1));
      alu_result = alu_f(alu_op, alu_a, alu_b);
      #1;
      if (req_ready != 4'b0) o.rdy_bad++;
      if (alu_start) begin
        o.starts++;
        if (o.first < 0) o.first = t;
      end
      if (!alu_reset_n) o.rlow++;
      if (busy) o.busy_cnt++;
      if (rsp_valid != 4'b0) begin
        o.lat = t; o.rspv = rsp_valid;
        o.res = rsp_result; o.err = rsp_error;
        got_rsp = 1'b1;
      end
      step();
    end
    req_valid = '0;
    alu_done  = 1'b0;
    #1;
    o.post_ok = (rsp_valid == 4'b0) && !busy && (req_ready == 4'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; req_op = 12'h249;
    req_a = '1; req_b = '1; alu_done = 1'b1; alu_result = 16'hFFFF;
    #3;
    n_checks++;
    if ({alu_start, alu_op, alu_a, alu_b, alu_reset_n} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_alu: got %h want 0",
               {alu_start, alu_op, alu_a, alu_b, alu_reset_n});
    end
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_rsp: got %h want 0",
               {rsp_valid, rsp_result, rsp_error});
    end
    step(); step();
    n_checks++;
    if (req_ready !== 4'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    req_valid = '0; alu_done = 1'b0; reset = 1'b0;
    #1;
    n_checks++;
    if (alu_reset_n !== 1'b0) begin
      n_err++; $display("FAIL rstn_before_edge: got %b want 0", alu_reset_n);
    end
    step();
    n_checks++;
    if (alu_reset_n !== 1'b1) begin
      n_err++; $display("FAIL rstn_after_edge: got %b want 1", alu_reset_n);
    end
    last_m = 3;
  endtask

  task automatic test_add();
    obs_t o;
    run_cmd(4'b0010, 12'h008, 32'h0000_FF00, 32'h0000_0100, 1, o);
    last_m = 1;
    n_checks++;
    if (o.gidx !== 1) begin
      n_err++; $display("FAIL add_grant: got %0d want 1", o.gidx);
    end
    n_checks++;
    if (o.first !== 1 || o.starts !== 1) begin
      n_err++;
      $display("FAIL add_start: first %0d cnt %0d want 1 1", o.first, o.starts);
    end
    n_checks++;
    if (o.lat !== 2 || o.rspv !== 4'b0010) begin
      n_err++;
      $display("FAIL add_rsp: lat %0d vec %b want 2 0010", o.lat, o.rspv);
    end
    n_checks++;
    if (o.res !== 16'h0100 || o.err !== 1'b0) begin
      n_err++;
      $display("FAIL add_result: got %h/%b want 0100/0", o.res, o.err);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [3:0] rem;
    int exp_r[4] = '{6, 9, 12, 15};
    do_reset();
    rem = 4'hF;
    for (int i = 0; i < 4; i++) begin
      run_cmd(rem, {4{3'd4}}, {8'd5, 8'd4, 8'd3, 8'd2}, {4{8'd3}}, i + 1, o);
      n_checks++;
      if (o.gidx !== i) begin
        n_err++; $display("FAIL rr_order: got %0d want %0d", o.gidx, i);
      end
      n_checks++;
      if (o.res !== 16'(exp_r[i])) begin
        n_err++; $display("FAIL rr_result: got %0d want %0d", o.res, exp_r[i]);
      end
      n_checks++;
      if (o.starts !== i + 1 || o.rdy_bad !== 0 || !o.post_ok) begin
        n_err++;
        $display("FAIL rr_overlap: starts %0d rdy %0d post %0d want %0d 0 1",
                 o.starts, o.rdy_bad, o.post_ok, i + 1);
      end
      rem[i] = 1'b0;
    end
    last_m = 3;
  endtask

  task automatic test_nop();
    obs_t o;
    run_cmd(4'b0100, 12'h000, 32'h0011_0000, 32'h0022_0000, 1, o);
    last_m = 2;
    n_checks++;
    if (o.gidx !== 2 || o.starts !== 1 || o.first !== 1) begin
      n_err++;
      $display("FAIL nop_start: grant %0d cnt %0d first %0d want 2 1 1",
               o.gidx, o.starts, o.first);
    end
    n_checks++;
    if (o.lat !== 2 || o.rspv !== 4'b0100 || o.res !== 16'h0 || o.err !== 1'b0) begin
      n_err++;
      $display("FAIL nop_rsp: lat %0d vec %b res %h err %b want 2 0100 0 0",
               o.lat, o.rspv, o.res, o.err);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    run_cmd(4'b0001, 12'h005, 32'h0000_0033, 32'h0000_0044, 1, o);
    last_m = 0;
    n_checks++;
    if (o.starts !== 0 || o.rlow !== 0) begin
      n_err++;
      $display("FAIL ill_alu: starts %0d rstn_low %0d want 0 0", o.starts, o.rlow);
    end
    n_checks++;
    if (o.lat !== 1 || o.rspv !== 4'b0001 || o.err !== 1'b1 || o.res !== 16'h0) begin
      n_err++;
      $display("FAIL ill_rsp: lat %0d vec %b err %b res %h want 1 0001 1 0",
               o.lat, o.rspv, o.err, o.res);
    end
  endtask

  task automatic test_rst_op();
    obs_t o;
    run_cmd(4'b1000, 12'hE00, 32'h0, 32'h0, 1, o);
    last_m = 3;
    n_checks++;
    if (o.starts !== 0 || o.rlow !== 1) begin
      n_err++;
      $display("FAIL rstop_alu: starts %0d rstn_low %0d want 0 1", o.starts, o.rlow);
    end
    n_checks++;
    if (o.lat !== 2 || o.rspv !== 4'b1000 || o.err !== 1'b0 || o.res !== 16'h0) begin
      n_err++;
      $display("FAIL rstop_rsp: lat %0d vec %b err %b res %h want 2 1000 0 0",
               o.lat, o.rspv, o.err, o.res);
    end
  endtask

`ifdef TINYALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_cmd(4'b0010, 12'h018, 32'h0000_5A00, 32'h0000_0F00, 0, o);
    last_m = 1;
    n_checks++;
    if (o.starts !== 16 || o.first !== 1) begin
      n_err++;
      $display("FAIL to_start: cnt %0d first %0d want 16 1", o.starts, o.first);
    end
    n_checks++;
    if (o.rlow !== 1) begin
      n_err++; $display("FAIL to_rstn: got %0d want 1", o.rlow);
    end
    n_checks++;
    if (o.lat !== 17 || o.err !== 1'b1 || o.res !== 16'h0) begin
      n_err++;
      $display("FAIL to_rsp: lat %0d err %b res %h want 17 1 0", o.lat, o.err, o.res);
    end
  endtask
`else
  task automatic test_long_wait();
    obs_t o;
    run_cmd(4'b0010, 12'h018, 32'h0000_5A00, 32'h0000_0F00, 25, o);
    last_m = 1;
    n_checks++;
    if (o.starts !== 25 || o.rlow !== 0) begin
      n_err++;
      $display("FAIL wait_start: cnt %0d rstn_low %0d want 25 0", o.starts, o.rlow);
    end
    n_checks++;
    if (o.lat !== 26 || o.err !== 1'b0 || o.res !== 16'h0055) begin
      n_err++;
      $display("FAIL wait_rsp: lat %0d err %b res %h want 26 0 0055",
               o.lat, o.err, o.res);
    end
  endtask
`endif

  task automatic test_random();
    obs_t o;
    logic [3:0] m;
    logic [11:0] ops;
    logic [31:0] as, bs;
    logic [2:0] op;
    logic [15:0] eres;
    int k, w, elat, est, efirst, erlow;
    bit ex, nop, ill;
    for (int n = 0; n < 40; n++) begin
      m   = 4'($urandom_range(1, 15));
      ops = 12'($urandom);
      as  = $urandom;
      bs  = $urandom;
      k   = int'($urandom_range(1, 8));
      run_cmd(m, ops, as, bs, k, o);
      w = rr_pick(m, last_m);
      last_m = w;
      op  = ops[3*w +: 3];
      ex  = op inside {3'd1, 3'd2, 3'd3, 3'd4};
      nop = (op == 3'd0);
      ill = (op == 3'd5) || (op == 3'd6);
      eres   = ex ? alu_f(op, as[8*w +: 8], bs[8*w +: 8]) : 16'h0;
      elat   = ex ? k + 1 : (ill ? 1 : 2);
      est    = ex ? k : (nop ? 1 : 0);
      efirst = (ex || nop) ? 1 : -1;
      erlow  = (op == 3'd7) ? 1 : 0;
      n_checks++;
      if (o.gidx !== w || o.rspv !== (4'b0001 << w)) begin
        n_err++;
        $display("FAIL rnd_grant: got %0d/%b want %0d", o.gidx, o.rspv, w);
      end
      n_checks++;
      if (o.lat !== elat || o.busy_cnt !== elat) begin
        n_err++;
        $display("FAIL rnd_latency: lat %0d busy %0d want %0d op %0d",
                 o.lat, o.busy_cnt, elat, op);
      end
      n_checks++;
      if (o.res !== eres || o.err !== ill) begin
        n_err++;
        $display("FAIL rnd_result: got %h/%b want %h/%b op %0d",
                 o.res, o.err, eres, ill, op);
      end
      n_checks++;
      if (o.starts !== est || o.first !== efirst || o.rlow !== erlow) begin
        n_err++;
        $display("FAIL rnd_alu: start %0d/%0d rlow %0d want %0d/%0d %0d op %0d",
                 o.starts, o.first, o.rlow, est, efirst, erlow, op);
      end
      n_checks++;
      if (o.rdy_bad !== 0 || !o.post_ok) begin
        n_err++;
        $display("FAIL rnd_handshake: rdy %0d post %0d want 0 1",
                 o.rdy_bad, o.post_ok);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    obs_t o;
    int seen = 0;
    bit got = 1'b0;
    do_reset();
    req_op = 12'h100; req_a = 32'h0005_0000; req_b = 32'h0007_0000;
    req_valid = 4'b0100; alu_done = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      #1;
      if (req_ready == 4'b0100) got = 1'b1;
      else step();
    end
    n_checks++;
    if (!got) begin
      n_err++; $display("FAIL mid_grant: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    step();
    n_checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_exec: start %b busy %b want 1 1", alu_start, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({alu_start, alu_op, alu_a, alu_b, alu_reset_n} !== 21'h0) begin
      n_err++;
      $display("FAIL mid_alu_reset: got %h want 0",
               {alu_start, alu_op, alu_a, alu_b, alu_reset_n});
    end
    n_checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_error, busy} !== 26'h0) begin
      n_err++;
      $display("FAIL mid_out_reset: got %h want 0",
               {req_ready, rsp_valid, rsp_result, rsp_error, busy});
    end
    step(); step();
    reset = 1'b0; alu_done = 1'b1; alu_result = 16'h1234;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (rsp_valid != 4'b0) seen++;
      step();
    end
    alu_done = 1'b0;
    last_m = 3;
    n_checks++;
    if (seen !== 0) begin
      n_err++; $display("FAIL mid_no_rsp: got %0d responses want 0", seen);
    end
    run_cmd(4'hF, 12'h249, 32'h0302_0100, 32'h0101_0101, 2, o);
    last_m = 0;
    n_checks++;
    if (o.gidx !== 0 || o.res !== 16'h0001) begin
      n_err++;
      $display("FAIL mid_next_grant: got %0d res %h want 0 0001", o.gidx, o.res);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0;
    test_reset();
    test_add();
    test_round_robin();
    test_nop();
    test_illegal();
    test_rst_op();
`ifdef TINYALU_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
